alu_adder_seq: RTL and testbench
================================

Name: alu_adder_seq

Overview:
- Multi-cycle sequencer that computes WIDTH-bit add/subtract by reusing one SLICE-bit adder slice, one slice per clock, least significant slice first, chaining carry through a register.
- Sits beside the MIPS-32 ALU as the area-reduced add/sub path, under start/busy/done handshake control from the execute-stage controller.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE.
- SLICE, 8, width of the shared adder slice.
- NSLICE, WIDTH/SLICE (derived, localparam), number of slice passes per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B; latched with operands.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high from the cycle after start is accepted until done deasserts.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- carry_out  output  1  final slice carry (for subtract: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, result, carry_out, overflow, zero all 0; slice index 0; carry register 0. Reset mid-operation abandons the operation with no done pulse; the first start after release is accepted normally.
- States: IDLE, RUN, DONE.
- IDLE: if start = 1 at an edge, latch a, op_sub, and b (b inverted if op_sub = 1). Set carry register to op_sub, index to 0, next state RUN. Otherwise stay in IDLE.
- RUN: each cycle, slice = a_lat[idx] + b_lat[idx] + carry. Write the SLICE-bit sum into result byte idx; the slice carry-out goes to the carry register. If idx = NSLICE-1, go to DONE; else idx+1.
- DONE: done = 1 for exactly this cycle. carry_out = final carry. overflow = (a_msb == b'_msb) && (result_msb != a_msb), where b' is the possibly inverted B. zero = (result == 0). Next state IDLE.
- Flags update only on entry to DONE; they hold with result until the next accepted start.
- result bytes may update during RUN; consumers use result only when done = 1 or afterwards in IDLE.
- busy = 1 in RUN and DONE, 0 in IDLE.
- Latency: start sampled at edge N; done high in the cycle after edge N+NSLICE (5 clocks for defaults).
- Back-to-back operations: a new start is accepted in the IDLE cycle after DONE (minimum issue interval NSLICE+2).
- start while busy (RUN or DONE): ignored, not queued. Operand changes during busy have no effect.
- Arithmetic is modulo 2^WIDTH; there are no exceptions.

Decomposition:
- Shared package alu_pkg holds:
  - localparam ALU_WIDTH = 32, ALU_SLICE = 8;
  - state enum IDLE/RUN/DONE;
  - op encoding ALU_OP_ADD = 0, ALU_OP_SUB = 1.
- One sub-module, alu_adder_slice: combinational SLICE-bit a + b + cin producing {cout, sum}.
- The index counter, FSM and result/flag registers live in alu_adder_seq.

Test Plan:
1. a=0x000000FF, b=0x00000001, add, start pulse -> done exactly 5 clocks later; result=0x00000100, carry_out=0, overflow=0, zero=0; carry propagated across the slice boundary.
2. a=0xFFFFFFFF, b=0x00000001, add -> result=0x00000000, carry_out=1, zero=1, overflow=0.
3. a=0x7FFFFFFF, b=0x00000001, add -> result=0x80000000, overflow=1, carry_out=0. Then a=0x80000000, b=0x00000001, sub -> result=0x7FFFFFFF, overflow=1, carry_out=1.
4. a=5, b=7, sub -> result=0xFFFFFFFE, carry_out=0, overflow=0. Then a=0x51, b=0x87, add -> result=0x000000D8, carry_out=0.
5. Issue a=1, b=2. Two clocks later pulse start with a=100, b=100 -> second start ignored; a single done arrives with result=3; busy stays high throughout. A start in the following IDLE cycle is accepted.
6. Assert rst_n low during RUN (idx=2) -> all outputs 0 immediately and no done pulse. After release, a=0x12345678, b=0x11111111, add -> result=0x23456789 at 5-clock latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS-32 ALU slice-serial add/sub path.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SLICE = 8;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_adder_slice.sv
// Combinational W-bit adder slice: {cout, sum} = a + b + cin.
module alu_adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/alu_adder_seq.sv
// Area-reduced add/sub: one shared SLICE-bit adder walks the operands LSB slice
// first, chaining the carry through a register, under start/busy/done control.
module alu_adder_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SLICE = ALU_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_params
    $error("alu_adder_seq: WIDTH must be a positive multiple of SLICE");
  end

  alu_state_e       state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [IW-1:0]    idx;
  logic             carry;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] result_nxt;

  // result_nxt is the result word with the current slice merged in, so the
  // zero/overflow flags can see the final slice in the same cycle it is written.
  always_comb begin
    slice_a    = a_lat[int'(idx)*SLICE +: SLICE];
    slice_b    = b_lat[int'(idx)*SLICE +: SLICE];
    result_nxt = result;
    result_nxt[int'(idx)*SLICE +: SLICE] = slice_sum;
  end

  alu_adder_slice #(
    .W (SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_lat     <= '0;
      b_lat     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with op_sub.
            a_lat <= a;
            b_lat <= (op_sub == ALU_OP_SUB) ? ~b : b;
            carry <= op_sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= result_nxt;
          carry  <= slice_cout;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            carry_out <= slice_cout;
            overflow  <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) &&
                         (result_nxt[WIDTH-1] != a_lat[WIDTH-1]);
            zero      <= (result_nxt == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_adder_seq.sv
// Scoreboard bench for alu_adder_seq: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever done is seen.
module tb_alu_adder_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ov;
    logic        zero;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  alu_adder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference: plain modular/signed arithmetic, independent of slicing.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    exp_t        e;
    longint      sx;
    longint      sy;
    longint      ideal;
    logic [31:0] r;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    ideal = sub ? (sx - sy) : (sx + sy);
    r     = sub ? (x - y) : (x + y);
    e.res  = r;
    e.cout = sub ? (x >= y) : ((33'(x) + 33'(y)) > 33'h0_FFFF_FFFF);
    e.ov   = (ideal != longint'($signed(r)));
    e.zero = (r == 32'd0);
    e.due  = 0;
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic iop);
    exp_t e;
    @(negedge clk);
    a      = ia;
    b      = ib;
    op_sub = iop;
    start  = 1'b1;
    e      = model(ia, ib, iop);
    e.due  = cyc + 5;
    q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_sub = 1'($urandom);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL done_timeout actual=pending%0d required=pending0", q.size());
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      checkOutput("done_pulse", 32'(prev_done), 32'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=done1 required=done0 result=0x%08h", result);
      end else begin
        last_exp = q.pop_front();
        checkOutput("result",    result,           last_exp.res);
        checkOutput("carry_out", 32'(carry_out),   32'(last_exp.cout));
        checkOutput("overflow",  32'(overflow),    32'(last_exp.ov));
        checkOutput("zero",      32'(zero),        32'(last_exp.zero));
        checkOutput("latency",   32'(cyc),         32'(last_exp.due));
        checkOutput("busy_done", 32'(busy),        32'd1);
      end
    end
    prev_done = rst_n && done;
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sub = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   32'(busy),      32'd0);
    checkOutput("rst_done",   32'(done),      32'd0);
    checkOutput("rst_result", result,         32'd0);
    checkOutput("rst_flags",  {29'd0, carry_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0); waitIdle();
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); waitIdle();
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); waitIdle();
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1); waitIdle();
    applyStimulus(32'd5,         32'd7,         1'b1); waitIdle();
    applyStimulus(32'h0000_0051, 32'h0000_0087, 1'b0); waitIdle();

    // Result and flags must hold in IDLE after the done pulse.
    repeat (2) @(negedge clk);
    checkOutput("hold_result", result,         last_exp.res);
    checkOutput("hold_flags",  {29'd0, carry_out, overflow, zero},
                {29'd0, last_exp.cout, last_exp.ov, last_exp.zero});
    checkOutput("hold_busy",   32'(busy),      32'd0);

    $display("[TB] start while busy is ignored");
    applyStimulus(32'd1, 32'd2, 1'b0);
    @(negedge clk);
    a = 32'd100; b = 32'd100; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_run0", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("busy_run1", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("busy_run2", 32'(busy), 32'd1);
    applyStimulus(32'h0000_1000, 32'h0000_0234, 1'b1); waitIdle();

    $display("[TB] reset during RUN");
    applyStimulus(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    checkOutput("midrst_busy",   32'(busy),   32'd0);
    checkOutput("midrst_done",   32'(done),   32'd0);
    checkOutput("midrst_result", result,      32'd0);
    checkOutput("midrst_flags",  {29'd0, carry_out, overflow, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0); waitIdle();

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      applyStimulus(ra, rb, 1'($urandom));
      waitIdle();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
